// File: rtl/data_mem_responder_if.sv
// Request/response bus between a CPU MEM stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ack_o;
  logic [31:0] data_o;
  logic        busy_o;
  logic        err_o;

  modport master (output req_i, we_i, addr_i, data_i, input ack_o, data_o, busy_o, err_o);
  modport slave  (input req_i, we_i, addr_i, data_i, output ack_o, data_o, busy_o, err_o);
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data memory: accepts one request in IDLE, acks LATENCY cycles later,
// flags misaligned or out-of-range accesses with err_o alongside the ack.
module data_mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          addr_err;
  logic          enter_ack;

  assign idx       = addr_q[AW+1:2];
  assign addr_err  = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);
  assign enter_ack = (state_q == S_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: if (bus.req_i) begin
        we_d    = bus.we_i;
        addr_d  = bus.addr_i;
        wdata_d = bus.data_i;
        cnt_d   = CNT_LOAD;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack_d  = enter_ack;
    err_d  = enter_ack && addr_err;
    busy_d = (state_d != S_IDLE);
    // Read data is held across writes; only a completed read or an error replaces it.
    data_d = data_q;
    if (enter_ack) begin
      if (addr_err)   data_d = 32'h0;
      else if (!we_q) data_d = mem[idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across rst_i.
  // A reset mid-access returns the FSM to IDLE, so enter_ack can never fire for the aborted write.
  always_ff @(posedge clk_i) begin
    if (enter_ack && we_q && !addr_err) mem[idx] <= wdata_q;
  end

  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;
  assign bus.err_o  = err_q;
  assign bus.data_o = data_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table on a LATENCY=4 instance plus
// hand sequences for back-to-back requests, reset mid-write and a LATENCY=1 instance.
module tb_data_mem_responder;
  logic clk;
  logic rst_n;

  data_mem_responder_if bus ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.LATENCY(4), .DEPTH(256)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the LATENCY=4 instance and checks latency, err, data and the single-cycle ack.
  task automatic run_txn(input vec_t v);
    int lat;
    bus.req_i  = 1'b1;
    bus.we_i   = v.we;
    bus.addr_i = v.addr;
    bus.data_i = v.wdata;
    tick();
    bus.req_i  = 1'b0;
    bus.we_i   = ~v.we;
    bus.addr_i = 32'hFFFF_FFFF;
    bus.data_i = 32'h5555_AAAA;
    check({v.name, " busy after accept"}, 32'(bus.busy_o), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({v.name, " ack latency"}, 32'(lat), 32'd4);
    check({v.name, " err"}, 32'(bus.err_o), 32'(v.exp_err));
    check({v.name, " data_o"}, bus.data_o, v.exp_data);
    tick();
    check({v.name, " ack/busy/err after"}, {29'd0, bus.ack_o, bus.busy_o, bus.err_o}, 32'd0);
  endtask

  vec_t vecs[11];
  vec_t rd20;

  initial begin
    vecs[0]  = '{"wr 0x10",        1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{"rd 0x10",        1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{"wr 0x00",        1'b1, 32'h0,   32'hA5A5_0001, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{"rd 0x13 misal",  1'b0, 32'h13,  32'h0,         1'b1, 32'h0};
    vecs[4]  = '{"wr 0x400 oob",   1'b1, 32'h400, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[5]  = '{"rd 0x00",        1'b0, 32'h0,   32'h0,         1'b0, 32'hA5A5_0001};
    vecs[6]  = '{"wr 0x3fc last",  1'b1, 32'h3FC, 32'h0BAD_F00D, 1'b0, 32'hA5A5_0001};
    vecs[7]  = '{"rd 0x3fc last",  1'b0, 32'h3FC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[8]  = '{"rd 0x400 oob",   1'b0, 32'h400, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{"wr 0x20",        1'b1, 32'h20,  32'h1111_2222, 1'b0, 32'h0};
    vecs[10] = '{"rd 0x10 again",  1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    rd20     = '{"rd 0x20 post-rst", 1'b0, 32'h20, 32'h0,        1'b0, 32'h1111_2222};

    bus.req_i = 1'b0;  bus.we_i = 1'b0;  bus.addr_i = 32'h0;  bus.data_i = 32'h0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = 32'h0; bus1.data_i = 32'h0;
    rst_n = 1'b0;
    #3;
    check("reset outputs", {bus.data_o[30:0], bus.ack_o} ^ {31'd0, bus.busy_o | bus.err_o}, 32'd0);
    check("reset data_o", bus.data_o, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // req_i held high: acceptance every 6 cycles, one IDLE cycle (busy low) between accesses.
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10;
    for (int j = 0; j < 18; j++) begin
      tick();
      check($sformatf("cont req cyc %0d {ack,busy}", j), {30'd0, bus.ack_o, bus.busy_o},
            {30'd0, (j % 6 == 4), (j % 6 != 5)});
    end
    bus.req_i = 1'b0;
    check("cont req data_o", bus.data_o, 32'hDEAD_BEEF);

    // Reset two cycles after accepting a write to 0x20.
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.data_i = 32'h1234_5678;
    tick();
    bus.req_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("mid-rst {ack,busy,err}", {29'd0, bus.ack_o, bus.busy_o, bus.err_o}, 32'd0);
    check("mid-rst data_o", bus.data_o, 32'h0);
    tick();
    tick();
    check("held-rst {ack,busy,err}", {29'd0, bus.ack_o, bus.busy_o, bus.err_o}, 32'd0);
    rst_n = 1'b1;
    run_txn(rd20);

    // LATENCY=1 instance: ack in the cycle after E0+1, idle after E0+2.
    bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.addr_i = 32'h8; bus1.data_i = 32'hCAFE_0001;
    tick();
    bus1.req_i = 1'b0;
    check("lat1 wr E0 {ack,busy}", {30'd0, bus1.ack_o, bus1.busy_o}, 32'b01);
    tick();
    check("lat1 wr E0+1 {ack,busy,err}", {29'd0, bus1.ack_o, bus1.busy_o, bus1.err_o}, 32'b110);
    tick();
    check("lat1 wr E0+2 {ack,busy}", {30'd0, bus1.ack_o, bus1.busy_o}, 32'b00);
    bus1.req_i = 1'b1; bus1.we_i = 1'b0; bus1.addr_i = 32'h8;
    tick();
    bus1.req_i = 1'b0;
    check("lat1 rd E0 {ack,busy}", {30'd0, bus1.ack_o, bus1.busy_o}, 32'b01);
    tick();
    check("lat1 rd E0+1 {ack,busy,err}", {29'd0, bus1.ack_o, bus1.busy_o, bus1.err_o}, 32'b110);
    check("lat1 rd data_o", bus1.data_o, 32'hCAFE_0001);
    tick();
    check("lat1 rd E0+2 {ack,busy}", {30'd0, bus1.ack_o, bus1.busy_o}, 32'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
